// File: rtl/serial_pkg.sv
// serial_pkg: shared types and defaults for the serial bit-stream blocks
package serial_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} ser_state_t;
   localparam int SER_DEFAULT_WIDTH = 8;
endpackage

// File: rtl/serial_word_shifter.sv
// serial_word_shifter: parallel-to-serial word shifter; optional even-parity trailer via SERIAL_PARITY_EN
module serial_word_shifter
   import serial_pkg::*;
#(
   parameter int WIDTH      = SER_DEFAULT_WIDTH,
   parameter bit MSB_FIRST  = 1'b1,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             valid_in,
   output logic             ready_out,
   output logic             x_out,
   output logic             x_valid,
   output logic             busy,
   output logic             done
);
   localparam int CW = $clog2(WIDTH + 1);
   ser_state_t       state;
   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] shifted;
   logic [CW-1:0]    cnt;
   logic             first_bit;
   logic             next_bit;
   logic             last;
`ifdef SERIAL_PARITY_EN
   logic             par;
`endif
   assign shifted   = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
   assign first_bit = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
   assign next_bit  = MSB_FIRST ? sreg[WIDTH-2] : sreg[1];
   assign last      = cnt == CW'(1);
   assign ready_out = state == IDLE;
   assign busy      = state != IDLE;
   // FSM, shift register, bit counter and registered serial outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         sreg    <= '0;
         cnt     <= '0;
         x_out   <= IDLE_LEVEL;
         x_valid <= 1'b0;
         done    <= 1'b0;
`ifdef SERIAL_PARITY_EN
         par     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (valid_in) begin
                  state   <= SHIFT;
                  sreg    <= data_in;
                  cnt     <= CW'(WIDTH);
                  x_out   <= first_bit;
                  x_valid <= 1'b1;
                  done    <= 1'b0;
`ifdef SERIAL_PARITY_EN
                  par     <= ^data_in;
`endif
               end
            end
            SHIFT: begin
               sreg <= shifted;
               cnt  <= cnt - 1'b1;
               if (last) begin
`ifdef SERIAL_PARITY_EN
                  state   <= PARITY;
                  x_out   <= par;
                  done    <= 1'b1;
`else
                  state   <= IDLE;
                  x_out   <= IDLE_LEVEL;
                  x_valid <= 1'b0;
                  done    <= 1'b0;
`endif
               end else begin
                  x_out <= next_bit;
`ifdef SERIAL_PARITY_EN
                  done  <= 1'b0;
`else
                  done  <= cnt == CW'(2);
`endif
               end
            end
`ifdef SERIAL_PARITY_EN
            PARITY: begin
               state   <= IDLE;
               x_out   <= IDLE_LEVEL;
               x_valid <= 1'b0;
               done    <= 1'b0;
            end
`endif
            default: begin
               state   <= IDLE;
               sreg    <= '0;
               cnt     <= '0;
               x_out   <= IDLE_LEVEL;
               x_valid <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_serial_word_shifter.sv
// tb_serial_word_shifter: scoreboard bench for an MSB-first and an LSB-first shifter
module tb_serial_word_shifter;
   import serial_pkg::*;
`ifdef SERIAL_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   typedef struct {
      logic x;
      logic d;
      int   cyc;
   } exp_t;
   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] din [2];
   logic [1:0] vin;
   logic [1:0] rdy;
   logic [1:0] xo;
   logic [1:0] xv;
   logic [1:0] bsy;
   logic [1:0] dn;
   exp_t       q [2][$];
   int         cyc = 0;
   int         checks = 0;
   int         errs = 0;
   bit         mon_on = 1'b0;
   int         h1;
   int         h2;
   serial_word_shifter #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) d0 (
      .clock(clock), .reset(reset), .data_in(din[0]), .valid_in(vin[0]), .ready_out(rdy[0]),
      .x_out(xo[0]), .x_valid(xv[0]), .busy(bsy[0]), .done(dn[0]));
   serial_word_shifter #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) d1 (
      .clock(clock), .reset(reset), .data_in(din[1]), .valid_in(vin[1]), .ready_out(rdy[1]),
      .x_out(xo[1]), .x_valid(xv[1]), .busy(bsy[1]), .done(dn[1]));
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask
   task automatic send(input int k, input logic [7:0] w, input bit keep, output int h);
      int n = 0;
      h = -1;
      din[k] = w;
      vin[k] = 1'b1;
      while (!rdy[k] && n < 40) begin
         @(negedge clock);
         n++;
      end
      if (!rdy[k]) check($sformatf("hs_timeout%0d", k), 0, 1);
      else begin
         @(posedge clock);
         h = cyc;
         for (int i = 0; i < 8; i++)
            q[k].push_back('{x: (k == 0) ? w[7-i] : w[i], d: (i == 7) && (PAR == 0), cyc: h + 1 + i});
         if (PAR != 0) q[k].push_back('{x: ^w, d: 1'b1, cyc: h + 9});
         #1;
         if (!keep) vin[k] = 1'b0;
      end
   endtask
   task automatic drain(input int k);
      int n = 0;
      while (q[k].size() != 0 && n < 50) begin
         @(negedge clock);
         n++;
      end
      check($sformatf("drain_timeout%0d", k), q[k].size(), 0);
      @(negedge clock);
   endtask
   always @(negedge clock) begin
      if (mon_on) begin
         for (int k = 0; k < 2; k++) begin
            exp_t e;
            check($sformatf("ready%0d", k), rdy[k], !xv[k]);
            check($sformatf("busy%0d", k), bsy[k], xv[k]);
            if (xv[k]) begin
               if (q[k].size() == 0) check($sformatf("unexpected_bit%0d", k), 1, 0);
               else begin
                  e = q[k].pop_front();
                  check($sformatf("x%0d", k), xo[k], e.x);
                  check($sformatf("done%0d", k), dn[k], e.d);
                  check($sformatf("latency%0d", k), cyc, e.cyc);
               end
            end else begin
               check($sformatf("idle_x%0d", k), xo[k], 1'b0);
               check($sformatf("idle_done%0d", k), dn[k], 1'b0);
               if (q[k].size() != 0 && q[k][0].cyc <= cyc) begin
                  check($sformatf("missing_bit%0d", k), 0, 1);
                  void'(q[k].pop_front());
               end
            end
         end
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
   initial begin
      reset = 1'b1;
      vin = 2'b00;
      din[0] = 8'h00;
      din[1] = 8'h00;
      @(posedge clock);
      @(negedge clock);
      mon_on = 1'b1;
      vin = 2'b11;
      din[0] = 8'hA5;
      din[1] = 8'hA5;
      repeat (5) begin
         check("rst_ready", rdy, 2'b11);
         check("rst_xvalid", xv, 2'b00);
         check("rst_xout", xo, 2'b00);
         check("rst_done", dn, 2'b00);
         @(negedge clock);
      end
      vin = 2'b00;
      reset = 1'b0;
      @(negedge clock);
      send(0, 8'hA5, 1'b0, h1);
      drain(0);
      send(1, 8'h01, 1'b0, h1);
      drain(1);
      send(0, 8'h3C, 1'b1, h1);
      din[0] = 8'h55;
      repeat (3) @(negedge clock);
      din[0] = 8'hFF;
      send(0, 8'hFF, 1'b0, h2);
      check("b2b_gap", h2 - h1, 9 + PAR);
      drain(0);
      send(0, 8'hA5, 1'b0, h1);
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      q[0].delete();
      @(negedge clock);
      check("midrst_xvalid", xv[0], 1'b0);
      check("midrst_xout", xo[0], 1'b0);
      check("midrst_ready", rdy[0], 1'b1);
      check("midrst_done", dn[0], 1'b0);
      reset = 1'b0;
      @(negedge clock);
      send(0, 8'h0F, 1'b0, h1);
      drain(0);
      send(0, 8'h07, 1'b0, h1);
      drain(0);
      send(1, 8'h07, 1'b0, h1);
      drain(1);
      for (int i = 0; i < 4; i++) begin
         send(i % 2, 8'($urandom_range(0, 255)), 1'b0, h1);
         drain(i % 2);
      end
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/serial_word_shifter.md
Name: serial_word_shifter

Overview:
- Parallel-to-serial stage that sits directly upstream of the team's serial bit-stream Moore detectors and produces their single-bit `x` input.
- Accepts one WIDTH-bit word over a valid/ready handshake, then emits it one bit per clock on `x_out` with a qualifying `x_valid`.
- Signals completion with a one-cycle `done` pulse.

Parameters:
WIDTH, 8, word width in bits; legal range 2..32.
MSB_FIRST, 1, 1 = bit WIDTH-1 emitted first; 0 = bit 0 emitted first.
IDLE_LEVEL, 0, value driven on x_out whenever x_valid is low.

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
data_in  input  WIDTH  word to serialise; sampled only on handshake
valid_in  input  1  data_in valid
ready_out  output  1  block can accept a word (high only in IDLE)
x_out  output  1  serial bit, registered
x_valid  output  1  x_out carries a payload (or parity) bit
busy  output  1  high in any non-IDLE state
done  output  1  one-cycle pulse in the cycle the final bit is on x_out

Behaviour:
- Interface: reset `reset`, synchronous, active-high; clock `clock`.
- Reset values: state=IDLE, x_out=IDLE_LEVEL, x_valid=0, done=0, busy=0, ready_out=1, shift register=0, bit counter=0.
- States:
  - IDLE: ready_out=1. On valid_in && ready_out at an edge, capture data_in into the shift register, load counter=WIDTH, go to SHIFT.
  - SHIFT: each cycle, the current bit is on x_out with x_valid=1. At each edge, shift toward the output end and decrement the counter. When counter==1 at an edge, go to IDLE (or PARITY when the feature is enabled).
  - PARITY: only exists with the feature; see Optional Feature.
- Latency: handshake at edge t gives the first bit on x_out from edge t+1. Bits occupy edges t+1..t+WIDTH.
- done=1 exactly during the last transmitted bit cycle: the final payload bit, or the parity bit when the feature is enabled.
- Throughput: one word per WIDTH+1 cycles (WIDTH+2 with parity), because ready_out is low while busy. There is no back-to-back acceptance.
- x_out, x_valid and done are registered, with no combinational path from inputs.
- ready_out and busy are decoded from state only.
- valid_in while busy: ignored. data_in changes while busy have no effect.
- The block holds no word once back in IDLE. A valid_in held high is accepted on the first IDLE edge.
- Reset mid-operation: the word is discarded and reset values apply at the next edge. No done pulse.
- Counter width: $clog2(WIDTH+1). The count never wraps, since the exit occurs at counter==1.
- Unused state encodings recover to IDLE with reset output values.

Optional Feature:
- Macro: SERIAL_PARITY_EN.
- Defined:
  - After the last payload bit the FSM enters PARITY for one cycle.
  - x_out = even-parity bit (XOR of the captured word), x_valid=1, done=1 in that cycle; the last payload bit has done=0.
  - Then return to IDLE.
- Undefined: the PARITY state, parity logic and parity register are absent. Behaviour is exactly as in SHIFT-only operation.

Decomposition:
- Shared package serial_pkg contains:
  - typedef enum logic [1:0] {IDLE, SHIFT, PARITY} ser_state_t;
  - localparam SER_DEFAULT_WIDTH = 8.
- Downstream detector state enums also belong in serial_pkg.
- No sub-module: a single FSM plus shift register and counter is the natural unit.

Test Plan:
- WIDTH=8, MSB_FIRST=1, valid_in pulse with 0xA5 -> x_out 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting one edge after handshake; x_valid high 8 cycles; done high only on 8th; ready_out low 8 cycles.
- MSB_FIRST=0, data 0x01 -> x_out 1,0,0,0,0,0,0,0; then x_out=IDLE_LEVEL (0) and x_valid=0.
- valid_in held high with 0x3C then 0xFF, switching data_in during the first word -> 0x3C sent intact; one IDLE cycle with ready_out=1; 0xFF sent next.
- Reset asserted after 3 bits of 0xA5 -> next edge x_valid=0, x_out=0, ready_out=1; no done pulse; a following word 0x0F is sent correctly.
- SERIAL_PARITY_EN, 0xA5 (four ones) -> 8 payload bits then parity bit 0 with done=1. With 0x07 -> parity bit 1; x_valid high 9 cycles.
- Reset held 5 cycles with valid_in=1 -> nothing accepted; all outputs at reset values throughout.
